// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver: scanner
// states, segment bit positions and the hex glyph table.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

    // Segment bit positions within the {g,f,e,d,c,b,a} vector.
    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    localparam logic [6:0] SEG_A = 7'(1 << SEG_A_BIT);
    localparam logic [6:0] SEG_B = 7'(1 << SEG_B_BIT);
    localparam logic [6:0] SEG_C = 7'(1 << SEG_C_BIT);
    localparam logic [6:0] SEG_D = 7'(1 << SEG_D_BIT);
    localparam logic [6:0] SEG_E = 7'(1 << SEG_E_BIT);
    localparam logic [6:0] SEG_F = 7'(1 << SEG_F_BIT);
    localparam logic [6:0] SEG_G = 7'(1 << SEG_G_BIT);

    // Active-high glyphs, entry 15 first; lower-case b and d keep them distinct from 8 and 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        SEG_A | SEG_E | SEG_F | SEG_G,                          // F
        SEG_A | SEG_D | SEG_E | SEG_F | SEG_G,                  // E
        SEG_B | SEG_C | SEG_D | SEG_E | SEG_G,                  // d
        SEG_A | SEG_D | SEG_E | SEG_F,                          // C
        SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,                  // b
        SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G,          // A
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G,          // 9
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,  // 8
        SEG_A | SEG_B | SEG_C,                                  // 7
        SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,          // 6
        SEG_A | SEG_C | SEG_D | SEG_F | SEG_G,                  // 5
        SEG_B | SEG_C | SEG_F | SEG_G,                          // 4
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_G,                  // 3
        SEG_A | SEG_B | SEG_D | SEG_E | SEG_G,                  // 2
        SEG_B | SEG_C,                                          // 1
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F           // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high segment decoder; a blanked digit lights nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_on
);

    assign seg_on = blank ? 7'h00 : HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: steps one digit per refresh edge with an
// all-off guard gap, and swaps in new display data only at frame wrap.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int GUARD_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GRD_W-1:0]      GUARD_LOAD = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};

    scan_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [GRD_W-1:0]        guard_cnt;
    logic [4*NUM_DIGITS-1:0] act_value, shd_value;
    logic [NUM_DIGITS-1:0]   act_dp, shd_dp;
    logic                    act_blz, shd_blz;

    logic scan_meta, scan_sync, scan_prev, scan_edge;

    // scan_clk is only trusted after two flops; the third gives the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_meta <= 1'b0;
            scan_sync <= 1'b0;
            scan_prev <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            scan_meta <= scan_clk;
            scan_sync <= scan_meta;
            scan_prev <= scan_sync;
        end
    end

    assign scan_edge = scan_sync & ~scan_prev;

    logic [IDX_W-1:0]        idx_inc, drive_idx;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] nxt_value;
    logic [NUM_DIGITS-1:0]   nxt_dp;
    logic                    nxt_blz;

    // Values that will be active after this edge, so the wrap digit already shows new data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nxt_value = act_value;
        nxt_dp    = act_dp;
        nxt_blz   = act_blz;
        idx_inc   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        drive_idx = (state == ST_BLANK) ? idx_inc : '0;
        wrap      = (state == ST_BLANK) && (guard_cnt == '0) && (idx == LAST_IDX);
        if (wrap && load) begin
            nxt_value = value;
            nxt_dp    = dp;
            nxt_blz   = blank_lz;
        end else if (wrap && update_pending) begin
            nxt_value = shd_value;
            nxt_dp    = shd_dp;
            nxt_blz   = shd_blz;
        end
    end

    logic [NUM_DIGITS-1:0] lz_mask;

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (nxt_value[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above && nxt_blz;
        end
    end

    logic [3:0]            drive_nibble;
    logic [6:0]            drive_seg_on;
    logic [NUM_DIGITS-1:0] an_drive;
    logic [6:0]            seg_drive;
    logic                  dp_drive;

    assign drive_nibble = nxt_value[drive_idx*4 +: 4];

    seg7_decode u_decode (
        .nibble (drive_nibble),
        .blank  (lz_mask[drive_idx]),
        .seg_on (drive_seg_on)
    );

    assign an_drive  = (NUM_DIGITS'(1) << drive_idx) ^ AN_OFF;
    assign seg_drive = drive_seg_on ^ SEG_OFF;
    assign dp_drive  = nxt_dp[drive_idx] ^ SEG_ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: display data is a few flops, not a memory array, so it is reset to a known blank value.
            state          <= ST_OFF;
            idx            <= '0;
            guard_cnt      <= '0;
            act_value      <= '0;
            act_dp         <= '0;
            act_blz        <= 1'b0;
            shd_value      <= '0;
            shd_dp         <= '0;
            shd_blz        <= 1'b0;
            update_pending <= 1'b0;
            frame_done     <= 1'b0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp_out         <= SEG_ACTIVE_LOW;
        end else begin
            frame_done <= 1'b0;

            // A load on the wrap edge is taken straight into active by nxt_*.
            if (wrap) begin
                act_value      <= nxt_value;
                act_dp         <= nxt_dp;
                act_blz        <= nxt_blz;
                update_pending <= 1'b0;
                frame_done     <= 1'b1;
            end else if (load) begin
                shd_value      <= value;
                shd_dp         <= dp;
                shd_blz        <= blank_lz;
                update_pending <= 1'b1;
            end

            case (state)
                ST_OFF: begin
                    if (scan_edge) begin
                        state  <= ST_DRIVE;
                        idx    <= '0;
                        an     <= an_drive;
                        seg    <= seg_drive;
                        dp_out <= dp_drive;
                    end
                end
                ST_DRIVE: begin
                    if (scan_edge) begin
                        state     <= ST_BLANK;
                        guard_cnt <= GUARD_LOAD;
                        an        <= AN_OFF;
                        seg       <= SEG_OFF;
                        dp_out    <= SEG_ACTIVE_LOW;
                    end
                end
                ST_BLANK: begin
                    // Refresh edges during the gap are dropped, not queued.
                    if (guard_cnt == '0) begin
                        state  <= ST_DRIVE;
                        idx    <= drive_idx;
                        an     <= an_drive;
                        seg    <= seg_drive;
                        dp_out <= dp_drive;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed 7-segment display driver that consumes the slow square-wave refresh clock produced by the display clock divider, e.g. 100 Hz from 50 MHz. On each refresh rising edge it advances to the next digit, with an anti-ghosting blank gap between digits. It decodes hex nibbles to segments and applies new display values only at frame boundaries, so a frame never shows a mix of old and new values.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- GUARD_CYCLES, 16: clk cycles with all anodes off between digits (≥1).
- AN_ACTIVE_LOW, 1: 1 = anode outputs active-low.
- SEG_ACTIVE_LOW, 1: 1 = segment and dp outputs active-low.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- scan_clk  in  1  divider output square wave; asynchronous to the scanner's internal phase, treated as an untrusted level.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 is least significant.
- dp  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  leading-zero blanking enable.
- load  in  1  one-cycle strobe that captures value, dp and blank_lz into the shadow register.
- an  out  NUM_DIGITS  digit anodes, one-hot when driving.
- seg  out  7  segments {g,f,e,d,c,b,a}, seg[0] = a.
- dp_out  out  1  decimal point of the current digit.
- update_pending  out  1  shadow holds data not yet applied.
- frame_done  out  1  one-cycle pulse when digit index wraps to 0.

## Operation
- scan_clk passes through a 2-flop synchronizer, then a rising-edge detector. The result is scan_edge, one clk cycle wide per scan_clk period.
- State machine:
  - OFF: after reset, anodes inactive. Leaves only on the first scan_edge, going to DRIVE with index 0.
  - DRIVE: the selected anode is active and seg/dp_out show digit index. On scan_edge, go to BLANK.
  - BLANK: all anodes inactive and seg off, for exactly GUARD_CYCLES cycles. Then go to DRIVE with index+1 (wrapping NUM_DIGITS-1 → 0).
  - scan_edge while in BLANK is ignored and is not queued.
- Index wrap (BLANK→DRIVE with new index 0):
  - frame_done pulses.
  - If update_pending is set, shadow is copied to active and update_pending clears.
- load behaviour:
  - load captures into shadow and sets update_pending.
  - load while already pending overwrites shadow; the last load wins.
  - load in the same cycle as a wrap bypasses shadow: the load data goes directly to active and update_pending stays 0.
- Decode uses the full hex range 0–F (A b C d E F styles).
- Leading-zero blanking, when the active blank_lz is set:
  - Scanning from digit NUM_DIGITS-1 downward, every zero nibble above the highest nonzero nibble shows no segments.
  - Digit 0 is never blanked.
  - dp is still shown on a blanked digit.
- Polarity: a logical "on" is inverted on an when AN_ACTIVE_LOW is set, and on seg/dp_out when SEG_ACTIVE_LOW is set.

## Timing
- Reset values:
  - an all inactive.
  - seg and dp_out off, at inactive polarity.
  - update_pending 0, frame_done 0.
  - Active and shadow registers 0, index 0, state OFF.
- Reset mid-operation returns immediately to these values; the next scan_edge restarts at digit 0.
- Latency from scan_clk to the outputs:
  - scan_clk first sampled high at clk edge N produces scan_edge high after edge N+1.
  - State changes to BLANK, with anodes off, at edge N+2.
  - The next digit drives at edge N+2+GUARD_CYCLES.
- All outputs are registered; an, seg and dp_out change on the same clk edge.
- frame_done is high for the cycle following the wrap edge.
- update_pending rises the cycle after load and falls the cycle after the wrap edge.

## Structure
- seg7_pkg holds:
  - the state enum (OFF, BLANK, DRIVE);
  - the 16-entry hex→segment constant table;
  - segment bit-position constants.
- Sub-module seg7_decode: combinational nibble + blank → 7-bit active-high segments, instantiated once on the muxed nibble.
- Top level holds the synchronizer, edge detector, FSM, guard counter, index counter, shadow/active registers and the leading-zero mask.

## Test plan
- Reset, then idle with scan_clk low for 1000 cycles:
  - an = 4'b1111, seg = 7'h7F, dp_out = 1, frame_done never pulses.
- value = 16'h12AF, dp = 4'b0100, 8 scan periods, both polarities active-low:
  - Digits 0..3 show F, A, 2, 1, each with an one-hot low.
  - dp_out is low only when index = 2.
  - A 16-cycle all-off gap separates every digit change.
- blank_lz = 1, value = 16'h0040:
  - Digits 3 and 2 are dark, digit 1 shows 4, digit 0 shows 0.
- value = 16'h0000 with blank_lz = 1:
  - Only digit 0 lights, showing 0.
- Load mid-frame:
  - During digit 1, load 16'h5555, then load 16'h7777 two cycles later.
  - Digits 2–3 still show the old value; update_pending = 1.
  - After the wrap, all digits show 7, update_pending = 0, frame_done pulses once.
- Assert load on the wrap cycle, then assert rst during BLANK:
  - Load on the wrap: new value is visible on digit 0 with no pending.
  - rst during BLANK: outputs return to reset values at once, and the next scan_edge drives digit 0.
